// File: rtl/tile_scheduler.sv
// tile_scheduler: sequences IFM/weight loads, systolic compute and OFM write-back
// over every output tile of one convolution layer (group -> column stripe -> row).
// The write-out of one tile overlaps the load of the next; compute of the next
// tile is held until the previous write has completed.
module tile_scheduler #(
  parameter int SYSTOLIC_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  ofm_size,
  input  logic [10:0] ofm_channel,
  input  logic        ifm_done,
  input  logic        wgt_done,
  input  logic        compute_done,
  input  logic        write_done,
  output logic        busy,
  output logic        ifm_load,
  output logic        wgt_load,
  output logic        compute_start,
  output logic        ofm_write_start,
  output logic [8:0]  tile_row,
  output logic [5:0]  tile_col,
  output logic [7:0]  tile_grp,
  output logic        layer_done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_LOAD, COMPUTE, WAIT_COMPUTE, WRITE, DRAIN, DONE
  } state_t;

  state_t      state;
  logic [8:0]  cfg_size;
  logic [10:0] cfg_ch;
  logic        ifm_seen, wgt_seen, write_pending;

  logic [5:0]  n_col;
  logic [7:0]  n_grp;
  logic        row_last, col_last, grp_last, tile_last;
  logic [8:0]  row_nx;
  logic [5:0]  col_nx;
  logic [7:0]  grp_nx;
  logic        ifm_any, wgt_any, wp_nx;

  // Tile counts from the latched config: ceil(x / S), zero-extended.
  assign n_col = 6'(({1'b0, cfg_size} + 10'(SYSTOLIC_SIZE - 1)) / 10'(SYSTOLIC_SIZE));
  assign n_grp = 8'(({1'b0, cfg_ch} + 12'(SYSTOLIC_SIZE - 1)) / 12'(SYSTOLIC_SIZE));

  assign row_last  = (tile_row == cfg_size - 9'd1);
  assign col_last  = (tile_col == n_col - 6'd1);
  assign grp_last  = (tile_grp == n_grp - 8'd1);
  assign tile_last = row_last && col_last && grp_last;

  // Sticky done flags including a done arriving this very cycle.
  assign ifm_any = ifm_seen | ifm_done;
  assign wgt_any = wgt_seen | wgt_done;
  // write_pending as it will be next cycle outside WRITE.
  assign wp_nx   = write_pending & ~write_done;

  // Next tile indices: row fastest, then column stripe, then filter group.
  always_comb begin
    row_nx = tile_row + 9'd1;
    col_nx = tile_col;
    grp_nx = tile_grp;
    if (row_last) begin
      row_nx = '0;
      col_nx = tile_col + 6'd1;
      if (col_last) begin
        col_nx = '0;
        grp_nx = tile_last ? 8'd0 : tile_grp + 8'd1;
      end
    end
  end

  // Main sequencer; all command outputs are registered and set on state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cfg_size        <= '0;
      cfg_ch          <= '0;
      ifm_seen        <= 1'b0;
      wgt_seen        <= 1'b0;
      write_pending   <= 1'b0;
      busy            <= 1'b0;
      ifm_load        <= 1'b0;
      wgt_load        <= 1'b0;
      compute_start   <= 1'b0;
      ofm_write_start <= 1'b0;
      layer_done      <= 1'b0;
      tile_row        <= '0;
      tile_col        <= '0;
      tile_grp        <= '0;
    end else begin
      // A write_done in the WRITE cycle belongs to no issued write and is dropped.
      if (state == WRITE)  write_pending <= 1'b1;
      else if (write_done) write_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            cfg_size <= ofm_size;
            cfg_ch   <= ofm_channel;
            tile_row <= '0;
            tile_col <= '0;
            tile_grp <= '0;
            busy     <= 1'b1;
            if (ofm_size == 9'd0 || ofm_channel == 11'd0) begin
              layer_done <= 1'b1;
              state      <= DONE;
            end else begin
              ifm_load <= 1'b1;
              wgt_load <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          ifm_load <= 1'b0;
          wgt_load <= 1'b0;
          ifm_seen <= 1'b0;
          // No weight fetch this tile: treat weights as already present.
          wgt_seen <= ~wgt_load;
          state    <= WAIT_LOAD;
        end
        WAIT_LOAD: begin
          ifm_seen <= ifm_any;
          wgt_seen <= wgt_any;
          if (ifm_any && wgt_any) begin
            compute_start <= ~wp_nx;
            state         <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (compute_start) begin
            compute_start <= 1'b0;
            state         <= WAIT_COMPUTE;
          end else begin
            compute_start <= ~wp_nx;
          end
        end
        WAIT_COMPUTE: begin
          if (compute_done) begin
            ofm_write_start <= 1'b1;
            state           <= WRITE;
          end
        end
        WRITE: begin
          ofm_write_start <= 1'b0;
          tile_row        <= row_nx;
          tile_col        <= col_nx;
          tile_grp        <= grp_nx;
          if (tile_last) begin
            state <= DRAIN;
          end else begin
            ifm_load <= 1'b1;
            wgt_load <= (row_nx == 9'd0) && (col_nx == 6'd0);
            state    <= LOAD;
          end
        end
        DRAIN: begin
          if (!wp_nx) begin
            layer_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          layer_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: table of layer configs and downstream latencies; an
// auto-responder plays the IFM/weight/array/write-back controllers, a monitor
// checks handshake latencies and pops the expected tile order from a scoreboard.
module tb_tile_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  ofm_size = '0;
  logic [10:0] ofm_channel = '0;
  logic        ifm_done = 1'b0, wgt_done = 1'b0, compute_done = 1'b0, write_done = 1'b0;
  logic        busy, ifm_load, wgt_load, compute_start, ofm_write_start, layer_done;
  logic [8:0]  tile_row;
  logic [5:0]  tile_col;
  logic [7:0]  tile_grp;

  tile_scheduler #(.SYSTOLIC_SIZE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ofm_size(ofm_size), .ofm_channel(ofm_channel),
    .ifm_done(ifm_done), .wgt_done(wgt_done), .compute_done(compute_done),
    .write_done(write_done), .busy(busy), .ifm_load(ifm_load), .wgt_load(wgt_load),
    .compute_start(compute_start), .ofm_write_start(ofm_write_start),
    .tile_row(tile_row), .tile_col(tile_col), .tile_grp(tile_grp), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [8:0] r; logic [5:0] c; logic [7:0] g; } tile_t;
  typedef struct {
    int size, ch, idly, wdly, cdly, rdly, stray, restart, tiles, wgts, lr, lc, lg;
  } vec_t;

  int tests = 0, fails = 0;
  int ifm_d = 1, wgt_d = 1, cmp_d = 1, wr_d = 1, stray = 0;
  tile_t exp_q[$];
  tile_t last_tile;
  int cyc = 0, n_ifm = 0, n_wgt = 0, n_cs = 0, n_ows = 0, n_wd = 0, n_ld = 0;
  int ready_cyc = 0, wd_cyc = 0, cd_cyc = 0, ows_cyc = 0;
  bit i_seen = 0, w_seen = 0, rdy = 0, cmp_out = 0, cd_pend = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic string nm(input int i, input string s);
    return $sformatf("v%0d_%s", i, s);
  endfunction

  // Downstream model: each request is answered after its programmed latency.
  initial begin
    int ic = 0, wc = 0, cc = 0, dc = 0, sc = 0;
    forever begin
      @(posedge clk); #2;
      ifm_done = 0; wgt_done = 0; compute_done = 0; write_done = 0;
      if (rst) begin
        ic = 0; wc = 0; cc = 0; dc = 0; sc = 0;
      end else begin
        if (ic > 0) begin ic--; if (ic == 0) ifm_done = 1; end
        if (wc > 0) begin wc--; if (wc == 0) wgt_done = 1; end
        if (cc > 0) begin cc--; if (cc == 0) compute_done = 1; end
        if (sc > 0) begin sc--; if (sc == 0) compute_done = 1; end
        if (dc > 0) begin dc--; if (dc == 0) write_done = 1; end
        if (ifm_load) begin ic = ifm_d; if (stray != 0) sc = 1; end
        if (wgt_load) wc = wgt_d;
        if (compute_start) cc = cmp_d;
        if (ofm_write_start) dc = wr_d;
      end
    end
  end

  // Monitor: latency rules and scoreboard of tile indices at compute_start.
  initial begin
    tile_t t;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rdy = 0; cmp_out = 0; cd_pend = 0; i_seen = 0; w_seen = 0;
      end else begin
        if (ifm_load) begin
          n_ifm++;
          if (n_ows > 0) chk("ifm_load_after_write", cyc - ows_cyc, 1);
          i_seen = 0; w_seen = !wgt_load; rdy = 0;
        end
        if (wgt_load) begin
          n_wgt++;
          chk("wgt_load_row", int'(tile_row), 0);
          chk("wgt_load_col", int'(tile_col), 0);
        end
        if (ifm_done) i_seen = 1;
        if (wgt_done) w_seen = 1;
        if (i_seen && w_seen && !rdy) begin rdy = 1; ready_cyc = cyc; end
        if (write_done) begin n_wd++; wd_cyc = cyc; end
        if (compute_start) begin
          n_cs++;
          chk("cs_after_ready", int'(rdy), 1);
          chk("cs_writes_drained", n_wd, n_ows);
          chk("cs_latency", cyc, ((n_ows > 0 && wd_cyc > ready_cyc) ? wd_cyc : ready_cyc) + 1);
          chk("sb_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("tile_row", int'(tile_row), int'(t.r));
            chk("tile_col", int'(tile_col), int'(t.c));
            chk("tile_grp", int'(tile_grp), int'(t.g));
          end
          last_tile = {tile_row, tile_col, tile_grp};
          cmp_out = 1;
        end else if (compute_done && cmp_out) begin
          cd_cyc = cyc; cd_pend = 1; cmp_out = 0;
        end
        if (ofm_write_start) begin
          n_ows++; ows_cyc = cyc;
          chk("ows_latency", cd_pend ? cyc - cd_cyc : -1, 1);
          cd_pend = 0;
        end
        if (layer_done) begin
          n_ld++;
          if (n_ows > 0) chk("ld_after_last_write", cyc - wd_cyc, 1);
        end
      end
    end
  end

  task automatic clear_counts();
    n_ifm = 0; n_wgt = 0; n_cs = 0; n_ows = 0; n_wd = 0; n_ld = 0;
    exp_q.delete();
  endtask

  task automatic push_layer(input int size, input int ch);
    int nc, ng;
    tile_t t;
    nc = (size + 15) / 16;
    ng = (ch + 15) / 16;
    if (size > 0 && ch > 0)
      for (int g = 0; g < ng; g++)
        for (int c = 0; c < nc; c++)
          for (int r = 0; r < size; r++) begin
            t.r = 9'(r); t.c = 6'(c); t.g = 8'(g);
            exp_q.push_back(t);
          end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int k;
    bit got;
    ifm_d = v.idly; wgt_d = v.wdly; cmp_d = v.cdly; wr_d = v.rdly; stray = v.stray;
    clear_counts();
    push_layer(v.size, v.ch);
    ofm_size = 9'(v.size); ofm_channel = 11'(v.ch); start = 1;
    @(posedge clk); #1;
    start = 0;
    // Config must be latched: scribble the inputs during the layer.
    ofm_size = 9'd7; ofm_channel = 11'd1;
    chk(nm(i, "busy_t1"), int'(busy), 1);
    chk(nm(i, "ifm_load_t1"), int'(ifm_load), int'(v.tiles > 0));
    chk(nm(i, "layer_done_t1"), int'(layer_done), int'(v.tiles == 0));
    got = layer_done; k = 0;
    while (!got && k < 3000) begin
      @(posedge clk); #1;
      k++;
      start = (v.restart != 0 && k == 5) ? 1'b1 : 1'b0;
      got = layer_done;
    end
    start = 0;
    chk(nm(i, "layer_done_seen"), int'(got), 1);
    if (!got) begin
      rst = 1; @(posedge clk); #1; rst = 0;
    end
    @(posedge clk); #1;
    chk(nm(i, "busy_after_done"), int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk(nm(i, "n_ifm_load"), n_ifm, v.tiles);
    chk(nm(i, "n_wgt_load"), n_wgt, v.wgts);
    chk(nm(i, "n_compute"), n_cs, v.tiles);
    chk(nm(i, "n_write"), n_ows, v.tiles);
    chk(nm(i, "n_layer_done"), n_ld, 1);
    chk(nm(i, "sb_left"), exp_q.size(), 0);
    if (v.tiles > 0) begin
      chk(nm(i, "last_row"), int'(last_tile.r), v.lr);
      chk(nm(i, "last_col"), int'(last_tile.c), v.lc);
      chk(nm(i, "last_grp"), int'(last_tile.g), v.lg);
    end
  endtask

  vec_t tbl[12];

  initial begin
    int k;
    //           size ch idly wdly cdly rdly stray rest tiles wgts lr lc lg
    tbl[0]  = '{ 4, 16, 1, 1, 1, 1,  0, 0,   4, 1,  3, 0, 0};
    tbl[1]  = '{20, 40, 1, 1, 1, 1,  0, 0, 120, 3, 19, 1, 2};
    tbl[2]  = '{ 4, 16, 3, 1, 1, 1,  0, 0,   4, 1,  3, 0, 0};
    tbl[3]  = '{ 4, 16, 1, 3, 1, 1,  0, 0,   4, 1,  3, 0, 0};
    tbl[4]  = '{ 4, 16, 2, 2, 1, 1,  0, 0,   4, 1,  3, 0, 0};
    tbl[5]  = '{ 4, 16, 3, 1, 1, 1,  1, 0,   4, 1,  3, 0, 0};
    tbl[6]  = '{ 3, 16, 1, 1, 1, 10, 0, 0,   3, 1,  2, 0, 0};
    tbl[7]  = '{17, 17, 1, 1, 2, 3,  0, 0,  68, 2, 16, 1, 1};
    tbl[8]  = '{ 4, 16, 1, 1, 1, 1,  0, 1,   4, 1,  3, 0, 0};
    tbl[9]  = '{ 5,  0, 1, 1, 1, 1,  0, 0,   0, 0,  0, 0, 0};
    tbl[10] = '{ 0,  5, 1, 1, 1, 1,  0, 0,   0, 0,  0, 0, 0};
    tbl[11] = '{16, 33, 2, 1, 1, 2,  0, 0,  48, 3, 15, 0, 2};

    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({ifm_load, wgt_load, compute_start, ofm_write_start, layer_done}), 0);
    chk("rst_row", int'(tile_row), 0);
    chk("rst_col", int'(tile_col), 0);
    chk("rst_grp", int'(tile_grp), 0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

    // Reset in the middle of WAIT_COMPUTE aborts without layer_done.
    ifm_d = 1; wgt_d = 1; cmp_d = 30; wr_d = 1; stray = 0;
    clear_counts();
    push_layer(4, 16);
    ofm_size = 9'd4; ofm_channel = 11'd16; start = 1;
    @(posedge clk); #1;
    start = 0;
    k = 0;
    while (!compute_start && k < 20) begin @(posedge clk); #1; k++; end
    chk("rst_reach_compute", int'(compute_start), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pulses", int'({ifm_load, wgt_load, compute_start, ofm_write_start, layer_done}), 0);
    chk("midrst_idx", int'(tile_row) + int'(tile_col) + int'(tile_grp), 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_layer_done", n_ld, 0);
    chk("midrst_no_write", n_ows, 0);
    chk("midrst_still_idle", int'(busy), 0);
    run_vec(12, tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
